// File: rtl/segasys_sndcmd_queue.sv
// Sound-command queue between main CPU and sound CPU, with a registered request/NMI pulse.
// Define SEGASYS_SNDQ_DROPOLD_EN to overwrite the oldest entry on overflow instead of dropping the new one.
module segasys_sndcmd_queue #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int RQ_HOLD = 64
) (
  input  logic                       clk48M,
  input  logic                       reset_n,
  input  logic                       wr_stb,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_stb,
  input  logic                       clr_ovf,
  output logic [DATA_W-1:0]          cmd_out,
  output logic                       sndrq,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT} rq_state_t;

  logic              wr_q, rd_q;
  logic              push, pop, push_ok, pop_ok, ovf_evt, drop_old;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] last_pop;
  rq_state_t         state, state_nxt;
  logic [7:0]        hold_cnt, hold_cnt_nxt;
  logic              sndrq_nxt;

  // Edge detectors start at 1 so a strobe already high at reset release is not an event.
  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b1;
      rd_q <= 1'b1;
    end else begin
      wr_q <= wr_stb;
      rd_q <= rd_stb;
    end
  end

  assign push    = wr_stb & ~wr_q;
  assign pop     = rd_stb & ~rd_q;
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

`ifdef SEGASYS_SNDQ_DROPOLD_EN
  assign drop_old = ovf_evt;
`else
  assign drop_old = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CNT_W'(1);
    else if (pop_ok && !push_ok)
      count_nxt = count - CNT_W'(1);
  end

  // When full, wr_ptr == rd_ptr, so dropping the oldest is a write plus a lockstep advance.
  always_ff @(posedge clk48M) begin
    if (push_ok || drop_old)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
      last_pop <= '0;
    end else begin
      if (push_ok || drop_old)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok || drop_old)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop_ok)
        last_pop <= mem[rd_ptr];
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
      if (ovf_evt)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

  assign cmd_out = empty ? last_pop : mem[rd_ptr];

  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      sndrq    <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      sndrq    <= sndrq_nxt;
    end
  end

  // A pop during PULSE returns to IDLE so any remaining entry raises a fresh request.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    sndrq_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt    = PULSE;
          hold_cnt_nxt = 8'(RQ_HOLD - 1);
          sndrq_nxt    = 1'b1;
        end
      end
      PULSE: begin
        if (pop_ok) begin
          state_nxt = IDLE;
        end else if (hold_cnt == '0) begin
          state_nxt = WAIT;
        end else begin
          hold_cnt_nxt = hold_cnt - 8'd1;
          sndrq_nxt    = 1'b1;
        end
      end
      WAIT: begin
        if (pop_ok)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_segasys_sndcmd_queue.sv
// Directed self-checking bench for segasys_sndcmd_queue (default parameters).
module tb_segasys_sndcmd_queue;

  logic       clk48M;
  logic       reset_n;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       rd_stb;
  logic       clr_ovf;
  logic [7:0] cmd_out;
  logic       sndrq;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  segasys_sndcmd_queue #(.DATA_W(8), .DEPTH(4), .RQ_HOLD(64)) dut (
    .clk48M (clk48M),
    .reset_n(reset_n),
    .wr_stb (wr_stb),
    .wr_data(wr_data),
    .rd_stb (rd_stb),
    .clr_ovf(clr_ovf),
    .cmd_out(cmd_out),
    .sndrq  (sndrq),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .ovf    (ovf)
  );

  initial clk48M = 1'b0;
  always #5 clk48M = ~clk48M;

  task automatic tick();
    @(posedge clk48M);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_data = d;
    wr_stb  = 1'b1;
    tick();
    wr_stb  = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; wr_stb = 1'b0; rd_stb = 1'b0; clr_ovf = 1'b0; wr_data = 8'h00;
    tick(); tick();
    checks++; if (count !== 3'd0)    begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("[TB] FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0)     begin errors++; $display("[TB] FAIL reset_full got %b want 0", full); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    checks++; if (cmd_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_cmd got %h want 00", cmd_out); end
    checks++; if (sndrq !== 1'b0)    begin errors++; $display("[TB] FAIL reset_sndrq got %b want 0", sndrq); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    int hi;
    wr_data = 8'h81;
    wr_stb  = 1'b1;
    tick();
    checks++; if (count !== 3'd1)    begin errors++; $display("[TB] FAIL push_count got %0d want 1", count); end
    checks++; if (cmd_out !== 8'h81) begin errors++; $display("[TB] FAIL push_cmd got %h want 81", cmd_out); end
    checks++; if (sndrq !== 1'b0)    begin errors++; $display("[TB] FAIL sndrq_early got %b want 0", sndrq); end
    tick();
    checks++; if (sndrq !== 1'b1)    begin errors++; $display("[TB] FAIL sndrq_rise got %b want 1", sndrq); end
    hi = sndrq ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sndrq) hi++;
    end
    wr_stb = 1'b0;
    for (int i = 0; i < 200 && sndrq; i++) begin
      tick();
      if (sndrq) hi++;
    end
    checks++; if (hi !== 64)         begin errors++; $display("[TB] FAIL sndrq_len got %0d want 64", hi); end
    checks++; if (count !== 3'd1)    begin errors++; $display("[TB] FAIL single_event got %0d want 1", count); end
    pop_one();
    checks++; if (empty !== 1'b1)    begin errors++; $display("[TB] FAIL pop_empty got %b want 1", empty); end
    checks++; if (cmd_out !== 8'h81) begin errors++; $display("[TB] FAIL last_popped got %h want 81", cmd_out); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_head;
    logic [7:0] exp_after [4];
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    checks++; if (full !== 1'b1)     begin errors++; $display("[TB] FAIL fill_full got %b want 1", full); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("[TB] FAIL fill_ovf got %b want 0", ovf); end
    push_byte(8'h14);
`ifdef SEGASYS_SNDQ_DROPOLD_EN
    exp_head = 8'h11;
`else
    exp_head = 8'h10;
`endif
    checks++; if (full !== 1'b1)     begin errors++; $display("[TB] FAIL ovf_full got %b want 1", full); end
    checks++; if (ovf !== 1'b1)      begin errors++; $display("[TB] FAIL ovf_set got %b want 1", ovf); end
    checks++; if (count !== 3'd4)    begin errors++; $display("[TB] FAIL ovf_count got %0d want 4", count); end
    checks++; if (cmd_out !== exp_head) begin errors++; $display("[TB] FAIL ovf_head got %h want %h", cmd_out, exp_head); end
    // Overflow and clear on the same edge: the overflow must win.
    wr_data = 8'h15; wr_stb = 1'b1; clr_ovf = 1'b1;
    tick();
    wr_stb = 1'b0; clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b1)      begin errors++; $display("[TB] FAIL ovf_priority got %b want 1", ovf); end
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0)      begin errors++; $display("[TB] FAIL ovf_clear got %b want 0", ovf); end
`ifdef SEGASYS_SNDQ_DROPOLD_EN
    exp_after[0] = 8'h13; exp_after[1] = 8'h14; exp_after[2] = 8'h15; exp_after[3] = 8'h15;
`else
    exp_after[0] = 8'h11; exp_after[1] = 8'h12; exp_after[2] = 8'h13; exp_after[3] = 8'h13;
`endif
    for (int i = 0; i < 4; i++) begin
      pop_one();
      checks++;
      if (cmd_out !== exp_after[i]) begin
        errors++; $display("[TB] FAIL drain_%0d got %h want %h", i, cmd_out, exp_after[i]);
      end
    end
    checks++; if (empty !== 1'b1)    begin errors++; $display("[TB] FAIL drain_empty got %b want 1", empty); end
  endtask

  task automatic test_pop_during_pulse();
    int hi;
    wr_data = 8'h20; wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
    tick();
    hi = sndrq ? 1 : 0;
    wr_data = 8'h21; wr_stb = 1'b1;
    tick();
    wr_stb = 1'b0;
    if (sndrq) hi++;
    for (int i = 0; i < 20 && hi < 9; i++) begin
      tick();
      if (sndrq) hi++;
    end
    checks++; if (hi !== 9)          begin errors++; $display("[TB] FAIL pulse_reach got %0d want 9", hi); end
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    checks++; if (sndrq !== 1'b0)    begin errors++; $display("[TB] FAIL pulse_drop got %b want 0", sndrq); end
    checks++; if (cmd_out !== 8'h21) begin errors++; $display("[TB] FAIL pulse_head got %h want 21", cmd_out); end
    checks++; if (count !== 3'd1)    begin errors++; $display("[TB] FAIL pulse_count got %0d want 1", count); end
    tick();
    checks++; if (sndrq !== 1'b1)    begin errors++; $display("[TB] FAIL rereq_rise got %b want 1", sndrq); end
    hi = sndrq ? 1 : 0;
    for (int i = 0; i < 200 && sndrq; i++) begin
      tick();
      if (sndrq) hi++;
    end
    checks++; if (hi !== 64)         begin errors++; $display("[TB] FAIL rereq_len got %0d want 64", hi); end
    pop_one();
    checks++; if (cmd_out !== 8'h21) begin errors++; $display("[TB] FAIL rereq_last got %h want 21", cmd_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_after [4];
    for (int i = 0; i < 4; i++) push_byte(8'h30 + 8'(i));
    wr_data = 8'h55; wr_stb = 1'b1; rd_stb = 1'b1;
    tick();
    wr_stb = 1'b0; rd_stb = 1'b0;
    checks++; if (count !== 3'd4)    begin errors++; $display("[TB] FAIL b2b_count got %0d want 4", count); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("[TB] FAIL b2b_ovf got %b want 0", ovf); end
    checks++; if (cmd_out !== 8'h31) begin errors++; $display("[TB] FAIL b2b_head got %h want 31", cmd_out); end
    tick();
    exp_after[0] = 8'h32; exp_after[1] = 8'h33; exp_after[2] = 8'h55; exp_after[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      pop_one();
      checks++;
      if (cmd_out !== exp_after[i]) begin
        errors++; $display("[TB] FAIL b2b_drain_%0d got %h want %h", i, cmd_out, exp_after[i]);
      end
    end
  endtask

  task automatic test_empty_pop();
    int seen;
    push_byte(8'h33);
    pop_one();
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    checks++; if (count !== 3'd0)    begin errors++; $display("[TB] FAIL epop_count got %0d want 0", count); end
    checks++; if (cmd_out !== 8'h33) begin errors++; $display("[TB] FAIL epop_cmd got %h want 33", cmd_out); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("[TB] FAIL epop_empty got %b want 1", empty); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (sndrq) seen++;
    end
    checks++; if (seen !== 0)        begin errors++; $display("[TB] FAIL epop_sndrq got %0d want 0", seen); end
  endtask

  task automatic test_reset_hold_strobe();
    wr_data = 8'h66; wr_stb = 1'b1;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (count !== 3'd0)    begin errors++; $display("[TB] FAIL hold_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("[TB] FAIL hold_empty got %b want 1", empty); end
    wr_stb = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    push_byte(8'h40);
    push_byte(8'h41);
    push_byte(8'h42);
    checks++; if (count !== 3'd3)    begin errors++; $display("[TB] FAIL pre_count got %0d want 3", count); end
    checks++; if (sndrq !== 1'b1)    begin errors++; $display("[TB] FAIL pre_sndrq got %b want 1", sndrq); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (sndrq !== 1'b0)    begin errors++; $display("[TB] FAIL ar_sndrq got %b want 0", sndrq); end
    checks++; if (count !== 3'd0)    begin errors++; $display("[TB] FAIL ar_count got %0d want 0", count); end
    checks++; if (ovf !== 1'b0)      begin errors++; $display("[TB] FAIL ar_ovf got %b want 0", ovf); end
    checks++; if (empty !== 1'b1)    begin errors++; $display("[TB] FAIL ar_empty got %b want 1", empty); end
    tick();
    reset_n = 1'b1;
    tick(); tick();
    checks++; if (sndrq !== 1'b0)    begin errors++; $display("[TB] FAIL ar_after got %b want 0", sndrq); end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_overflow();
    test_pop_during_pulse();
    test_back_to_back();
    test_empty_pop();
    test_reset_hold_strobe();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
